bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Round-robin arbiter that shares one port of the true-dual-port, byte-write-enable, read-first BRAM between NUM_REQ requesters. It grants at most one request per cycle and drives the BRAM port directly. It tracks the one-cycle read latency so each read response is steered back to the requester that issued it. Optional per-requester lock keeps back-to-back bursts uninterrupted. It sits between the CGRA load/store and configuration clients and a single BRAM port; a second instance can serve the other port.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_WIDTH, 12: BRAM word-address width.
- DATA_WIDTH, 64: BRAM word width; must be a multiple of 8.
- NUM_BYTES, DATA_WIDTH/8: byte lanes per word.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when valid & ready.
- req_lock  in  NUM_REQ  when set on an accepted request, hold the grant for that requester's next request.
- req_we  in  NUM_REQ*NUM_BYTES  byte write enables; requester i occupies slice i. All zero means read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  word address, slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data, slice i.
- resp_valid  out  NUM_REQ  one-hot; response for requester i's accepted read.
- resp_data  out  DATA_WIDTH  shared response data; valid only when a resp_valid bit is set.
- mem_ena  out  1  BRAM port enable.
- mem_we  out  NUM_BYTES  BRAM byte write enables.
- mem_addr  out  ADDR_WIDTH  BRAM address.
- mem_din  out  DATA_WIDTH  BRAM write data.
- mem_dout  in  DATA_WIDTH  BRAM registered read data; appears one cycle after the enable.

## Operation
- State: rr_ptr (log2 NUM_REQ bits), lock_active, lock_owner, resp_pending (NUM_REQ one-hot register).
- Arbitration is combinational in the request cycle.
  - If lock_active and req_valid[lock_owner]: grant lock_owner only.
  - Otherwise scan from rr_ptr upward, wrapping modulo NUM_REQ; grant the first valid requester.
  - No valid request: no grant.
- On a grant g:
  - mem_ena=1, mem_addr/mem_we/mem_din taken from slice g, req_ready[g]=1.
  - With no grant: mem_ena=0, mem_we=0; mem_addr and mem_din are don't-care, driven to 0.
- Pointer update after a grant to g:
  - Not under an active lock: rr_ptr <= (g+1) mod NUM_REQ.
  - Under an active lock: rr_ptr is unchanged.
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED->LOCKED: grant to g with req_lock[g]=1; lock_owner <= g.
  - LOCKED->LOCKED: grant to the owner with req_lock=1.
  - LOCKED->UNLOCKED: grant to the owner with req_lock=0, then rr_ptr <= owner+1.
  - LOCKED->UNLOCKED: req_valid[owner]=0 in any cycle. Lock is released and normal round-robin from rr_ptr arbitrates that same cycle.
- Responses:
  - resp_pending <= one-hot g when the granted request has req_we all zero; otherwise 0.
  - resp_valid = resp_pending; resp_data = mem_dout, passed through combinationally.
  - Writes produce no response.
  - Mixed read/write across requesters at one address: read-first order is inherited from the BRAM.
- Responses have no backpressure; requesters must accept resp_valid when it is asserted.

## Timing
- Grant is combinational in the request cycle. Throughput is 1 transfer per cycle.
- Read latency: resp_valid is asserted exactly 1 cycle after acceptance.
- Reset, in the cycle reset is high:
  - req_ready=0, mem_ena=0, mem_we=0.
  - Next state: rr_ptr=0, lock_active=0, resp_pending=0, so resp_valid=0 in the first cycle after reset.
- Reset mid-operation: any in-flight read response is dropped, and the lock is cleared. BRAM contents are not reset.
- Fairness: with all requesters continuously valid and unlocked, each requester is granted once every NUM_REQ cycles.

## Test plan
- Single read:
  - Preload addr 0x010 = 0xDEADBEEF00000001; requester 2 reads 0x010.
  - Required: req_ready[2]=1 in the same cycle; next cycle resp_valid=4'b0100 and resp_data=0xDEADBEEF00000001.
- Round-robin after reset: all 4 requesters valid for 8 cycles, reads, no lock. Grants must be 0,1,2,3,0,1,2,3.
- Wrap-around: rr_ptr=3 after a grant to 2; requesters 0 and 3 valid. Required grant order is 3, then 0.
- Lock burst:
  - Requester 1 issues 3 reads with lock=1,1,0 while requesters 0 and 2 stay valid.
  - Required grants: 1,1,1, then 2, then 0.
  - Repeat, but drop requester 1's valid after its first locked transfer. Required: requester 2 is granted in the same cycle.
- Byte write then read:
  - Requester 0 writes 0xFFFF...FF with we=0x01 to a word holding 0.
  - Required: no resp_valid for the write. Requester 0 then reads the word and gets 0x00000000000000FF.
- Reset mid-operation:
  - Assert reset in the cycle a read is granted under an active lock.
  - Required: resp_valid=0 in the following cycle, lock cleared, and the first grant after reset goes to the lowest valid index.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin arbiter sharing one BRAM port between requesters
//
// Purpose:
//    Grants at most one of NUM_REQ requesters per cycle onto a single
//    read-first, byte-write-enable BRAM port. Read responses are steered back
//    to the issuing requester one cycle later. A requester may hold the grant
//    across back-to-back requests with req_lock.
//
// Ports:
//    clock, reset          single clock, synchronous active-high reset
//    req_valid/req_ready   per-requester handshake, req_ready is a one-hot grant
//    req_lock              keep the grant for the owner's next request
//    req_we/addr/wdata     flattened per-requester request slices
//    resp_valid/resp_data  one-hot read response, data shared by all requesters
//    mem_*                 BRAM port (enable, byte writes, address, din, dout)

module bram_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 64,
   parameter int NUM_BYTES  = DATA_WIDTH / 8
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0]              req_lock,
   input  logic [NUM_REQ*NUM_BYTES-1:0]    req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]              resp_valid,
   output logic [DATA_WIDTH-1:0]           resp_data,
   output logic                            mem_ena,
   output logic [NUM_BYTES-1:0]            mem_we,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_din,
   input  logic [DATA_WIDTH-1:0]           mem_dout
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

   lock_state_e          lock_state_q, lock_state_d;
   logic [PTR_W-1:0]     lock_owner_q, lock_owner_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]   resp_pending_q, resp_pending_d;

   logic                 grant_valid;
   logic                 grant_locked;
   logic [PTR_W-1:0]     grant_idx;
   logic [PTR_W-1:0]     cand;
   logic [PTR_W-1:0]     next_ptr;
   logic [NUM_BYTES-1:0] grant_we;

   // Arbitration: a live lock owner wins outright; otherwise the first valid
   // requester at or after rr_ptr. Nothing is granted while reset is high.
   always_comb begin
      grant_valid  = 1'b0;
      grant_locked = 1'b0;
      grant_idx    = '0;
      cand         = '0;
      if (!reset) begin
         if (lock_state_q == LOCKED && req_valid[lock_owner_q]) begin
            grant_valid  = 1'b1;
            grant_locked = 1'b1;
            grant_idx    = lock_owner_q;
         end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
               cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
               if (!grant_valid && req_valid[cand]) begin
                  grant_valid = 1'b1;
                  grant_idx   = cand;
               end
            end
         end
      end
   end

   assign grant_we  = req_we[grant_idx*NUM_BYTES +: NUM_BYTES];
   assign next_ptr  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   assign req_ready = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
   assign mem_ena   = grant_valid;
   assign mem_we    = grant_valid ? grant_we : '0;
   assign mem_addr  = grant_valid ? req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign mem_din   = grant_valid ? req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

   // BRAM dout is already registered, so the pending flag lines up with it.
   assign resp_valid = resp_pending_q;
   assign resp_data  = mem_dout;

   always_comb begin
      rr_ptr_d       = rr_ptr_q;
      lock_state_d   = lock_state_q;
      lock_owner_d   = lock_owner_q;
      resp_pending_d = '0;
      if (grant_valid) begin
         if (grant_locked) begin
            // Owner's burst continues; the pointer only moves when it ends.
            if (!req_lock[grant_idx]) begin
               lock_state_d = UNLOCKED;
               rr_ptr_d     = next_ptr;
            end
         end else begin
            // Covers both the plain unlocked case and an owner that dropped
            // valid this cycle, whose lock is released in favour of round-robin.
            rr_ptr_d = next_ptr;
            if (req_lock[grant_idx]) begin
               lock_state_d = LOCKED;
               lock_owner_d = grant_idx;
            end else begin
               lock_state_d = UNLOCKED;
            end
         end
         if (grant_we == '0) begin
            resp_pending_d = NUM_REQ'(1) << grant_idx;
         end
      end else begin
         // No grant while locked means the owner's valid is low.
         lock_state_d = UNLOCKED;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q       <= '0;
         lock_state_q   <= UNLOCKED;
         lock_owner_q   <= '0;
         resp_pending_q <= '0;
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         lock_state_q   <= lock_state_d;
         lock_owner_q   <= lock_owner_d;
         resp_pending_q <= resp_pending_d;
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed self-checking bench for bram_port_arbiter

module tb_bram_port_arbiter;

   localparam int NR = 4;
   localparam int AW = 12;
   localparam int DW = 64;
   localparam int NB = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_lock;
   logic [NR*NB-1:0]  req_we;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     resp_valid;
   logic [DW-1:0]     resp_data;
   logic              mem_ena;
   logic [NB-1:0]     mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_din;
   logic [DW-1:0]     mem_dout;

   logic              pre_en;
   logic [AW-1:0]     pre_addr;
   logic [DW-1:0]     pre_data;
   logic [DW-1:0]     mem [0:(1<<AW)-1];

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   bram_port_arbiter #(
      .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTES(NB)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .mem_ena(mem_ena), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   // Read-first BRAM model with registered output and a bench-side preload port.
   always_ff @(posedge clock) begin
      if (pre_en) begin
         mem[pre_addr] <= pre_data;
      end else if (mem_ena) begin
         mem_dout <= mem[mem_addr];
         for (int b = 0; b < NB; b++) begin
            if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_lock  = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic set_req(input int i, input logic lk, input logic [NB-1:0] we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]           = 1'b1;
      req_lock[i]            = lk;
      req_we[i*NB +: NB]     = we;
      req_addr[i*AW +: AW]   = a;
      req_wdata[i*DW +: DW]  = d;
   endtask

   initial begin
      logic [NR-1:0] prev_grant;
      reset    = 1'b1;
      pre_en   = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      clear_reqs();

      // Preload while in reset, then check reset-cycle outputs with live requests.
      step();
      pre_en = 1'b1; pre_addr = 12'h010; pre_data = 64'hDEADBEEF00000001;
      step();
      pre_addr = 12'h020; pre_data = 64'h0;
      step();
      pre_en = 1'b0;
      set_req(0, 1'b0, 8'hFF, 12'h030, 64'h1234);
      set_req(1, 1'b0, 8'h00, 12'h010, 64'h0);
      set_req(2, 1'b1, 8'h00, 12'h010, 64'h0);
      set_req(3, 1'b0, 8'h00, 12'h010, 64'h0);
      #1;
      check("reset_ready", 64'(req_ready), 64'h0);
      check("reset_ena",   64'(mem_ena),   64'h0);
      check("reset_we",    64'(mem_we),    64'h0);
      step();
      reset = 1'b0;
      clear_reqs();
      #1;
      check("post_reset_resp", 64'(resp_valid), 64'h0);

      // Single read by requester 2.
      set_req(2, 1'b0, 8'h00, 12'h010, 64'h0);
      #1;
      check("rd_ready", 64'(req_ready), 64'h4);
      check("rd_addr",  64'(mem_addr),  64'h010);
      step();
      clear_reqs();
      #1;
      check("rd_resp_valid", 64'(resp_valid), 64'h4);
      check("rd_resp_data",  resp_data, 64'hDEADBEEF00000001);

      // Round-robin from a fresh reset: 0,1,2,3,0,1,2,3.
      reset = 1'b1;
      step();
      reset = 1'b0;
      prev_grant = '0;
      for (int c = 0; c < 8; c++) begin
         for (int r = 0; r < NR; r++) set_req(r, 1'b0, 8'h00, AW'(c), 64'h0);
         #1;
         check($sformatf("rr_grant_%0d", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
         if (c > 0) check($sformatf("rr_resp_%0d", c), 64'(resp_valid), 64'(prev_grant));
         prev_grant = 4'(4'b0001 << (c % 4));
         step();
      end

      // Wrap-around: grant 2 moves the pointer to 3, then 3 before 0.
      clear_reqs();
      set_req(2, 1'b0, 8'h00, 12'h0, 64'h0);
      #1;
      check("wrap_g2", 64'(req_ready), 64'h4);
      step();
      clear_reqs();
      set_req(0, 1'b0, 8'h00, 12'h0, 64'h0);
      set_req(3, 1'b0, 8'h00, 12'h0, 64'h0);
      #1;
      check("wrap_g3", 64'(req_ready), 64'h8);
      step();
      #1;
      check("wrap_g0", 64'(req_ready), 64'h1);
      step();

      // Lock burst by requester 1: 1,1,1 then 2 then 0.
      clear_reqs();
      set_req(0, 1'b0, 8'h00, 12'h0, 64'h0);
      set_req(1, 1'b1, 8'h00, 12'h0, 64'h0);
      set_req(2, 1'b0, 8'h00, 12'h0, 64'h0);
      #1;
      check("lock_g1a", 64'(req_ready), 64'h2);
      step();
      #1;
      check("lock_g1b", 64'(req_ready), 64'h2);
      step();
      req_lock[1] = 1'b0;
      #1;
      check("lock_g1c", 64'(req_ready), 64'h2);
      step();
      req_valid[1] = 1'b0;
      #1;
      check("lock_g2", 64'(req_ready), 64'h4);
      step();
      #1;
      check("lock_g0", 64'(req_ready), 64'h1);
      step();

      // Lock released by owner dropping valid: requester 2 wins that cycle.
      set_req(1, 1'b1, 8'h00, 12'h0, 64'h0);
      #1;
      check("drop_g1", 64'(req_ready), 64'h2);
      step();
      req_valid[1] = 1'b0;
      #1;
      check("drop_g2", 64'(req_ready), 64'h4);
      step();

      // Byte write of lane 0 then read back.
      clear_reqs();
      set_req(0, 1'b0, 8'h01, 12'h020, 64'hFFFFFFFFFFFFFFFF);
      #1;
      check("wr_ready", 64'(req_ready), 64'h1);
      check("wr_we",    64'(mem_we),    64'h01);
      step();
      clear_reqs();
      set_req(0, 1'b0, 8'h00, 12'h020, 64'h0);
      #1;
      check("wr_no_resp", 64'(resp_valid), 64'h0);
      step();
      clear_reqs();
      #1;
      check("wr_rd_valid", 64'(resp_valid), 64'h1);
      check("wr_rd_data",  resp_data, 64'h00000000000000FF);

      // Reset while requester 1 holds a lock with a read in flight.
      set_req(1, 1'b1, 8'h00, 12'h010, 64'h0);
      #1;
      check("rst_lock_g1", 64'(req_ready), 64'h2);
      step();
      reset = 1'b1;
      #1;
      check("rst_mid_ready", 64'(req_ready), 64'h0);
      step();
      reset = 1'b0;
      clear_reqs();
      set_req(0, 1'b0, 8'h00, 12'h010, 64'h0);
      set_req(1, 1'b1, 8'h00, 12'h010, 64'h0);
      #1;
      check("rst_mid_resp",  64'(resp_valid), 64'h0);
      check("rst_mid_grant", 64'(req_ready),  64'h1);
      step();
      clear_reqs();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
